// File: rtl/br_stack_ctrl.sv
// Branch stack control sequencer: mask ownership, checkpoint allocation, resolve broadcast and recovery.
// Optional saturating performance counters are enabled by defining BR_CTRL_PERF_EN.
`ifndef BR_STATE_W
`define BR_STATE_W 2
`endif
`ifndef BR_NONE
`define BR_NONE 2'd0
`endif
`ifndef BR_PR_CORRECT
`define BR_PR_CORRECT 2'd1
`endif
`ifndef BR_PR_WRONG
`define BR_PR_WRONG 2'd2
`endif

module br_stack_ctrl #(
   parameter int BR_NUM = 4,
   parameter int PERF_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   dispatch_en_i,
   output logic [BR_NUM-1:0]      br_dep_mask_o,
   output logic [BR_NUM-1:0]      br_alloc_1hot_o,
   input  logic                   br_rslv_vld_i,
   input  logic [BR_NUM-1:0]      br_rslv_1hot_i,
   input  logic                   br_rslv_correct_i,
   output logic [BR_NUM-1:0]      br_mask_o,
   output logic [BR_NUM-1:0]      br_1hot_o,
   output logic [`BR_STATE_W-1:0] br_state_o,
   output logic [BR_NUM-1:0]      rc_sel_o,
   output logic [BR_NUM-1:0]      squash_mask_o,
   output logic [BR_NUM-1:0]      clear_mask_o,
   output logic                   full_o,
   output logic                   dispatch_stall_o
`ifdef BR_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0]      perf_br_cnt_o,
   output logic [PERF_W-1:0]      perf_mispred_cnt_o,
   output logic [PERF_W-1:0]      perf_full_stall_cnt_o
`endif
);

   typedef enum logic [0:0] {S_NORM = 1'b0, S_RCV = 1'b1} state_t;

   localparam logic [BR_NUM-1:0] ONE = BR_NUM'(1);

   state_t                         state_q, state_d;
   logic [BR_NUM-1:0]              mask_q, mask_d;
   logic [BR_NUM-1:0][BR_NUM-1:0]  dep_q, dep_d;

   logic              rslv_vld_s, wrong_s, correct_s, full_s, stall_s;
   logic [BR_NUM-1:0] dep_sel_s, alloc_s, clear_s, squash_s;

   function automatic logic is_onehot(input logic [BR_NUM-1:0] v);
      return (v != '0) && ((v & (v - ONE)) == '0);
   endfunction

   function automatic logic [BR_NUM-1:0] lowest_zero(input logic [BR_NUM-1:0] m);
      logic [BR_NUM-1:0] r;
      r = '0;
      for (int i = BR_NUM - 1; i >= 0; i--) begin
         if (!m[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Resolve qualification, allocation and the per-entry broadcast.
   always_comb begin
      rslv_vld_s = br_rslv_vld_i & is_onehot(br_rslv_1hot_i) & (|(br_rslv_1hot_i & mask_q));
      wrong_s    = rslv_vld_s & ~br_rslv_correct_i;
      correct_s  = rslv_vld_s & br_rslv_correct_i;
      dep_sel_s  = '0;
      for (int k = 0; k < BR_NUM; k++) begin
         if (br_rslv_1hot_i[k]) begin
            dep_sel_s = dep_sel_s | dep_q[k];
         end else begin
            dep_sel_s = dep_sel_s;
         end
      end
      full_s   = &mask_q;
      stall_s  = full_s | wrong_s | (state_q == S_RCV);
      alloc_s  = (dispatch_en_i && !stall_s) ? lowest_zero(mask_q) : '0;
      clear_s  = correct_s ? br_rslv_1hot_i : '0;
      // Killed set: every live slot not older than the wrong branch.
      squash_s = wrong_s ? (mask_q & ~dep_sel_s) : '0;

      br_mask_o        = mask_q;
      br_dep_mask_o    = mask_q;
      br_alloc_1hot_o  = alloc_s;
      br_1hot_o        = rslv_vld_s ? br_rslv_1hot_i : '0;
      rc_sel_o         = wrong_s ? br_rslv_1hot_i : '0;
      squash_mask_o    = squash_s;
      clear_mask_o     = clear_s;
      full_o           = full_s;
      dispatch_stall_o = stall_s;
      if (wrong_s) begin
         br_state_o = `BR_PR_WRONG;
      end else if (correct_s) begin
         br_state_o = `BR_PR_CORRECT;
      end else begin
         br_state_o = `BR_NONE;
      end
   end

   // Next mask, dependency and FSM state.
   always_comb begin
      mask_d  = mask_q;
      dep_d   = dep_q;
      state_d = S_NORM;
      if (wrong_s) begin
         mask_d  = dep_sel_s;
         state_d = S_RCV;
         for (int i = 0; i < BR_NUM; i++) begin
            dep_d[i] = squash_s[i] ? '0 : dep_q[i];
         end
      end else begin
         // Allocation and clear coexist; the new slot records the pre-allocation mask minus the freed bit.
         mask_d = (mask_q & ~clear_s) | alloc_s;
         for (int i = 0; i < BR_NUM; i++) begin
            dep_d[i] = alloc_s[i] ? (mask_q & ~clear_s) : (dep_q[i] & ~clear_s);
         end
      end
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_NORM;
         mask_q  <= '0;
         dep_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         dep_q   <= dep_d;
      end
   end

`ifdef BR_CTRL_PERF_EN
   logic [PERF_W-1:0] br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d, fst_cnt_q, fst_cnt_d;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] c, input logic en);
      if (en && (c != {PERF_W{1'b1}})) begin
         return c + PERF_W'(1);
      end else begin
         return c;
      end
   endfunction

   // Saturating event counters.
   always_comb begin
      br_cnt_d  = sat_inc(br_cnt_q, |alloc_s);
      mis_cnt_d = sat_inc(mis_cnt_q, wrong_s);
      fst_cnt_d = sat_inc(fst_cnt_q, dispatch_en_i & full_s);
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
         fst_cnt_q <= '0;
      end else begin
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
         fst_cnt_q <= fst_cnt_d;
      end
   end

   assign perf_br_cnt_o         = br_cnt_q;
   assign perf_mispred_cnt_o    = mis_cnt_q;
   assign perf_full_stall_cnt_o = fst_cnt_q;
`endif

endmodule
